// File: rtl/sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sync_tx_arbiter
//  Brief    : Source-domain round-robin arbiter that shares one bus
//             synchronizer channel. The winner's word is latched onto
//             unsync_bus and framed by a fixed-length bus_enable pulse,
//             followed by a fixed quiet gap before the next grant.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_tx_arbiter #(
  parameter int BUS_WIDTH   = 8,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BUS_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]           grant,
  output logic [BUS_WIDTH-1:0]       unsync_bus,
  output logic                       bus_enable,
  output logic                       busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_LAST_RST  = IDX_W'(N_REQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 en_q, en_d;
  logic [N_REQ-1:0]     grant_q, grant_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;
  int                   cand;

  logic [BUS_WIDTH-1:0] data_arr [N_REQ];

  // Split the flat request data vector into one word per requester
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_q) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // State register plus all registered outputs; reset abandons any transfer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= C_LAST_RST;
      bus_q   <= '0;
      en_q    <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      grant_q <= grant_d;
    end
  end

  // Next-state and hold/gap counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_HOLD;
          cnt_d   = C_HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = C_GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values: latch word and raise enable on grant, drop enable after hold
  always_comb begin
    grant_d = '0;
    bus_d   = bus_q;
    en_d    = en_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          bus_d            = data_arr[win_idx];
          en_d             = 1'b1;
          last_d           = win_idx;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          en_d = 1'b0;
        end
      end
      default: begin
        en_d = 1'b0;
      end
    endcase
  end

  assign grant      = grant_q;
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_tx_arbiter
//  Brief    : Directed scoreboard bench for sync_tx_arbiter (default params)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_tx_arbiter;

  localparam int BW = 8;
  localparam int NR = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0] grant;
  logic [BW-1:0] unsync_bus;
  logic          bus_enable;
  logic          busy;

  typedef struct {
    int            idx;
    logic [BW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_cnt = 0;
  int            grant_time = 0;
  int            prev_time = 0;
  logic [BW-1:0] last_bus = '0;

  sync_tx_arbiter #(
    .BUS_WIDTH  (BW),
    .N_REQ      (NR),
    .HOLD_CYCLES(4),
    .GAP_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .unsync_bus(unsync_bus),
    .bus_enable(bus_enable),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure grant spacing
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int idx, input logic [BW-1:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next grant; between grants the bus must not move
  task automatic wait_grant(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (grant !== '0) seen = 1'b1;
      else check({tag, " bus stable"}, 32'(unsync_bus), 32'(last_bus));
    end
    if (sb.size() == 0) begin
      check({tag, " unexpected grant"}, 32'(grant), 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " grant"}, 32'(grant), 32'd1 << e.idx);
      if (seen) begin
        check({tag, " data"}, 32'(unsync_bus), 32'(e.data));
        check({tag, " enable"}, 32'(bus_enable), 32'd1);
      end
      last_bus   = e.data;
      prev_time  = grant_time;
      grant_time = cyc_cnt;
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy === 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    cyc(3);

    // Reset state
    check("rst grant", 32'(grant), 32'd0);
    check("rst enable", 32'(bus_enable), 32'd0);
    check("rst bus", 32'(unsync_bus), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Single requester with full hold/gap profile
    req_data[2*BW +: BW] = 8'hA5;
    req[2] = 1'b1;
    push(2, 8'hA5);
    wait_grant("single");
    req[2] = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      @(negedge clk);
      check($sformatf("single en p%0d", p), 32'(bus_enable), 32'(p < 4));
      check($sformatf("single busy p%0d", p), 32'(busy), 32'(p < 7));
      check($sformatf("single grant p%0d", p), 32'(grant), 32'd0);
      check($sformatf("single bus p%0d", p), 32'(unsync_bus), 32'hA5);
    end

    // Fresh reset so requester 0 leads, then all four requesters held
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    last_bus = '0;
    for (int i = 0; i < NR; i++) begin
      req_data[i*BW +: BW] = 8'(8'h10 + i);
      push(i, 8'(8'h10 + i));
    end
    req = 4'hF;
    for (int i = 0; i < NR; i++) begin
      wait_grant($sformatf("all4 #%0d", i));
      if (i > 0) check($sformatf("all4 spacing #%0d", i), 32'(grant_time - prev_time), 32'd8);
    end
    req = '0;
    wait_idle("all4");

    // Fairness: after requester 2, requesters 3 then 0
    req_data[2*BW +: BW] = 8'h22;
    req_data[3*BW +: BW] = 8'h33;
    req_data[0*BW +: BW] = 8'h00;
    req[2] = 1'b1;
    push(2, 8'h22);
    wait_grant("fair r2");
    req = 4'b1001;
    push(3, 8'h33);
    push(0, 8'h00);
    wait_grant("fair r3");
    req[3] = 1'b0;
    wait_grant("fair r0");
    req[0] = 1'b0;
    wait_idle("fair");

    // Late request raised during another transfer's hold
    req_data[2*BW +: BW] = 8'h42;
    req[2] = 1'b1;
    push(2, 8'h42);
    wait_grant("late r2");
    req[2] = 1'b0;
    cyc(2);
    check("late busy in hold", 32'(busy), 32'd1);
    req_data[1*BW +: BW] = 8'h51;
    req[1] = 1'b1;
    push(1, 8'h51);
    wait_grant("late r1");
    check("late spacing", 32'(grant_time - prev_time), 32'd8);
    req[1] = 1'b0;

    // Withdrawn request: one-cycle pulse during gap is never granted
    cyc(5);
    req_data[0*BW +: BW] = 8'hEE;
    req[0] = 1'b1;
    cyc(1);
    req[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("withdraw grant c%0d", i), 32'(grant), 32'd0);
      check($sformatf("withdraw bus c%0d", i), 32'(unsync_bus), 32'h51);
    end

    // Reset asserted on the second hold cycle
    req_data[3*BW +: BW] = 8'h77;
    req[3] = 1'b1;
    push(3, 8'h77);
    wait_grant("rsthold r3");
    req[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req_data[0*BW +: BW] = 8'hA0;
    req_data[1*BW +: BW] = 8'hB1;
    req = 4'b0011;
    @(negedge clk);
    check("rsthold enable", 32'(bus_enable), 32'd0);
    check("rsthold bus", 32'(unsync_bus), 32'd0);
    check("rsthold busy", 32'(busy), 32'd0);
    check("rsthold grant", 32'(grant), 32'd0);
    last_bus = '0;
    rst = 1'b1;
    push(0, 8'hA0);
    wait_grant("tie r0");
    req[0] = 1'b0;
    push(1, 8'hB1);
    wait_grant("tie r1");
    req = '0;
    wait_idle("end");
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_tx_arbiter.md
# sync_tx_arbiter

Source-domain controller that shares one bus synchronizer channel between several requesters. It arbitrates round-robin among them and latches the winner's word onto the unsynchronized bus. It then frames that word with a bus-enable level pulse of fixed length, followed by a fixed quiet gap. The destination synchronizer therefore always sees a stable bus and a clean rising edge on bus enable.

## Interface
- `BUS_WIDTH`, default 8: width of each data word and of `unsync_bus`.
- `N_REQ`, default 4: number of requesters (≥ 2).
- `HOLD_CYCLES`, default 4: number of cycles `bus_enable` stays high per transfer (≥ 1).
- `GAP_CYCLES`, default 3: number of cycles `bus_enable` stays low after each transfer before the next grant (≥ 1).
- `clk` in 1: single clock. All logic is posedge.
- `rst` in 1: reset is synchronous and active-low.
- `req` in N_REQ: per-requester request level.
- `req_data` in N_REQ*BUS_WIDTH: requester i's word is in bits [i*BUS_WIDTH +: BUS_WIDTH].
- `grant` out N_REQ: one-hot, one-cycle pulse marking the accepted requester.
- `unsync_bus` out BUS_WIDTH: registered word driven to the synchronizer.
- `bus_enable` out 1: registered enable level driven to the synchronizer.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, HOLD, GAP. A down-counter of width clog2(max(HOLD_CYCLES, GAP_CYCLES)+1) times HOLD and GAP.
- Round-robin pointer `last` holds the index of the last granted requester.
  - Search order is last+1, last+2, … modulo N_REQ. The first set `req` bit wins.
  - `last` updates to the winner on each grant.
- IDLE, when any `req` is high at a posedge:
  - Register `unsync_bus` ← the winner's `req_data` slice.
  - Set `bus_enable` ← 1 and pulse `grant`[winner] ← 1 for one cycle.
  - Load the counter with HOLD_CYCLES-1 and go to HOLD.
- IDLE, when no `req` is high: all outputs hold. `bus_enable`=0 and `unsync_bus` keeps its last value.
- HOLD: decrement the counter. When it reaches 0, set `bus_enable` ← 0, load the counter with GAP_CYCLES-1, and go to GAP.
- GAP: decrement the counter. When it reaches 0, go to IDLE.
- `req` is ignored outside IDLE.
- `req_data` is sampled only at the granting edge.
- A requester must hold `req` until it sees `grant`. Dropping `req` before grant withdraws the request with no side effects.
- A requester that keeps `req` high after its grant counts as a new request in a later IDLE cycle.
- `unsync_bus` changes only at a granting edge. It is stable throughout HOLD and GAP, and stays stable afterwards until the next grant.

## Timing
- Reset, sampled at a posedge with `rst`=0, forces:
  - state = IDLE, counter = 0, `last` = N_REQ-1, so requester 0 has first priority;
  - `bus_enable` = 0, `unsync_bus` = 0, `grant` = 0, `busy` = 0.
- Reset overrides everything, including mid-HOLD or mid-GAP. `bus_enable` drops on that same edge and the transfer in progress is abandoned.
- Latency: a `req` seen at edge k produces `grant` and `bus_enable`=1 visible after edge k.
- `bus_enable` is high for exactly HOLD_CYCLES cycles, then low for at least GAP_CYCLES cycles.
- Back-to-back transfer period with continuous requests is HOLD_CYCLES+GAP_CYCLES+1 cycles; this includes the single IDLE decision cycle.
- `busy` is high from the cycle after the grant edge through the last GAP cycle.
- Simultaneous requests: exactly one grant per IDLE decision. The others wait without loss.

## Test plan
- Single requester: `req`[2]=1 with data 0xA5 after reset → `grant`=4'b0100 for 1 cycle, `unsync_bus`=0xA5, `bus_enable` high for 4 cycles then low for 3, `busy` high for 7 cycles.
- All four requesters held high with data 0x10/0x11/0x12/0x13 → grants in order 0,1,2,3 at 8-cycle spacing. Each `unsync_bus` value stays stable for its full 8-cycle window.
- Fairness: after a grant to requester 2, raise `req`[0] and `req`[3] together → requester 3 is granted first, then requester 0.
- Late request: raise `req`[1] during HOLD of another transfer → no effect until IDLE; granted on the first IDLE edge; `bus_enable` gap ≥ 3 cycles.
- Withdrawn request: `req`[0] pulsed for 1 cycle during GAP, low at IDLE → no grant; `unsync_bus` unchanged.
- Reset mid-HOLD: assert `rst`=0 on the 2nd HOLD cycle → next edge gives `bus_enable`=0, `unsync_bus`=0, `busy`=0. After release, requester 0 wins a tie with requester 1.
